// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared state encoding and default timing constants for the SR command sequencer
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SET_PULSE = 2'd1,
    ST_CLR_PULSE = 2'd2,
    ST_GAP       = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_DEB_CYCLES = 4;
  localparam int unsigned DEF_DEB_W      = 3;
  localparam int unsigned DEF_PULSE_W    = 2;

  // Pulse-width counter needs at least one bit even when PULSE_W is 1.
  function automatic int unsigned pcnt_width(input int unsigned pulse_w);
    return (pulse_w > 1) ? $clog2(pulse_w) : 1;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - two-flop synchroniser, stability counter and rising-edge press detect for one button
module sr_debounce #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEB_W      = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_prev_q;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - debounced set/clear buttons turned into exclusive fixed-width s/r pulses
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned DEB_W      = DEF_DEB_W,
  parameter int unsigned PULSE_W    = DEF_PULSE_W
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic ovr
);

  localparam int unsigned       PCNT_W    = pcnt_width(PULSE_W);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);

  logic              set_press;
  logic              clr_press;
  seq_state_e        state_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              set_pend_q;
  logic              set_pend_d;
  logic              clr_pend_q;
  logic              clr_pend_d;
  logic              ovr_q;
  logic              ovr_d;
  logic              s_q;
  logic              r_q;
  logic              busy_q;
  logic              dispatch;
  logic              take_clr;
  logic              take_set;

  sr_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_set_deb (
    .clk_i   (clk),
    .rst_ni  (reset),
    .btn_i   (set_btn),
    .press_o (set_press)
  );

  sr_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_clr_deb (
    .clk_i   (clk),
    .rst_ni  (reset),
    .btn_i   (clr_btn),
    .press_o (clr_press)
  );

  // GAP dispatches like IDLE so back-to-back requests are separated by a single low cycle.
  assign dispatch = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign take_clr = dispatch & clr_pend_q;
  assign take_set = dispatch & ~clr_pend_q & set_pend_q;

  always_comb begin
    set_pend_d = set_press | (set_pend_q & ~take_set);
    clr_pend_d = clr_press | (clr_pend_q & ~take_clr);
    ovr_d      = (set_press & set_pend_q & ~take_set) |
                 (clr_press & clr_pend_q & ~take_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      set_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      set_pend_q <= set_pend_d;
      clr_pend_q <= clr_pend_d;
      ovr_q      <= ovr_d;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          pcnt_q <= '0;
          if (take_clr) begin
            state_q <= ST_CLR_PULSE;
            s_q     <= 1'b0;
            r_q     <= 1'b1;
            busy_q  <= 1'b1;
          end else if (take_set) begin
            state_q <= ST_SET_PULSE;
            s_q     <= 1'b1;
            r_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_SET_PULSE, ST_CLR_PULSE: begin
          if (pcnt_q == PCNT_LAST) begin
            state_q <= ST_GAP;
            pcnt_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          s_q     <= 1'b0;
          r_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb/tb_sr_cmd_sequencer.sv - directed self-checking bench for sr_cmd_sequencer
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic set_btn = 1'b0;
  logic clr_btn = 1'b0;
  logic s, r, busy, ovr;
  logic f_set = 1'b0;
  logic f_clr = 1'b0;
  logic fs, fr, fbusy, fovr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sr_cmd_sequencer u_dut (
    .clk     (clk),
    .reset   (reset),
    .set_btn (set_btn),
    .clr_btn (clr_btn),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .ovr     (ovr)
  );

  // Short debounce and long pulse so two debounced presses fit inside one busy window.
  sr_cmd_sequencer #(
    .DEB_CYCLES (1),
    .DEB_W      (2),
    .PULSE_W    (8)
  ) u_fast (
    .clk     (clk),
    .reset   (reset),
    .set_btn (f_set),
    .clr_btn (f_clr),
    .s       (fs),
    .r       (fr),
    .busy    (fbusy),
    .ovr     (fovr)
  );

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({s, r, busy, ovr} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_initial got=%b want=0000", {s, r, busy, ovr});
    end
    for (int c = 0; c < 3; c++) begin
      set_btn = c[0];
      clr_btn = ~c[0];
      f_set   = ~c[0];
      f_clr   = c[0];
      @(posedge clk); #1;
      total++;
      if ({s, r, busy, ovr} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold c=%0d got=%b want=0000", c, {s, r, busy, ovr});
      end
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    f_set   = 1'b0;
    f_clr   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_set();
    logic exp_s, exp_b;
    for (int e = 1; e <= 20; e++) begin
      set_btn = 1'b1;
      @(posedge clk); #1;
      exp_s = (e == 8 || e == 9);
      exp_b = (e >= 8 && e <= 10);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL single_set_s e=%0d got=%b want=%b", e, s, exp_s);
      end
      total++;
      if (busy !== exp_b) begin
        bad++;
        $display("FAIL single_set_busy e=%0d got=%b want=%b", e, busy, exp_b);
      end
      total++;
      if (r !== 1'b0 || ovr !== 1'b0) begin
        bad++;
        $display("FAIL single_set_r_ovr e=%0d got=%b%b want=00", e, r, ovr);
      end
    end
    set_btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 30; e++) begin
      set_btn = (e <= 12) ? (((e - 1) / 2) % 2 == 0) : 1'b0;
      @(posedge clk); #1;
      total++;
      if (s !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bounce e=%0d got s=%b busy=%b want s=0 busy=0", e, s, busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_s, exp_r, exp_b;
    for (int e = 1; e <= 16; e++) begin
      set_btn = 1'b1;
      clr_btn = 1'b1;
      @(posedge clk); #1;
      exp_r = (e == 8 || e == 9);
      exp_s = (e == 11 || e == 12);
      exp_b = (e >= 8 && e <= 13);
      total++;
      if (r !== exp_r || s !== exp_s) begin
        bad++;
        $display("FAIL simul_sr e=%0d got s=%b r=%b want s=%b r=%b", e, s, r, exp_s, exp_r);
      end
      total++;
      if (busy !== exp_b) begin
        bad++;
        $display("FAIL simul_busy e=%0d got=%b want=%b", e, busy, exp_b);
      end
      total++;
      if ((s & r) !== 1'b0) begin
        bad++;
        $display("FAIL simul_excl e=%0d got s&r=%b want=0", e, s & r);
      end
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_merge_ovr();
    logic exp_s, exp_r, exp_o;
    for (int e = 1; e <= 26; e++) begin
      f_clr = 1'b1;
      f_set = (e == 4 || e == 5 || e >= 8);
      @(posedge clk); #1;
      exp_r = (e >= 5 && e <= 12);
      exp_s = (e >= 14 && e <= 21);
      exp_o = (e == 11);
      total++;
      if (fr !== exp_r || fs !== exp_s) begin
        bad++;
        $display("FAIL merge_sr e=%0d got s=%b r=%b want s=%b r=%b", e, fs, fr, exp_s, exp_r);
      end
      total++;
      if (fovr !== exp_o) begin
        bad++;
        $display("FAIL merge_ovr e=%0d got=%b want=%b", e, fovr, exp_o);
      end
    end
    f_set = 1'b0;
    f_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_s;
    for (int e = 1; e <= 8; e++) begin
      set_btn = 1'b1;
      @(posedge clk); #1;
      exp_s = (e == 8);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL midrst_pre e=%0d got=%b want=%b", e, s, exp_s);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (s !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got s=%b busy=%b want 0 0", s, busy);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (s !== 1'b0 || r !== 1'b0) begin
        bad++;
        $display("FAIL midrst_hold c=%0d got s=%b r=%b want 0 0", c, s, r);
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      exp_s = (e == 8 || e == 9);
      total++;
      if (s !== exp_s || r !== 1'b0) begin
        bad++;
        $display("FAIL midrst_post e=%0d got s=%b r=%b want s=%b r=0", e, s, r, exp_s);
      end
    end
    set_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_bounce();
    test_simultaneous();
    test_merge_ovr();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
